gf_muls_4_seq: RTL and testbench
================================

GF_MULS_4_SEQ -- requirements
Module: gf_muls_4_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the completed-operation counter.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, operand pair valid.
REQ-005 SHALL have port in_ready, output, 1, block can accept an operand pair.
REQ-006 SHALL have port a, input, 4, GF(2^4) operand, normal basis; a[3:2]=ah, a[1:0]=al.
REQ-007 SHALL have port b, input, 4, GF(2^4) operand, same layout; b[3:2]=bh, b[1:0]=bl.
REQ-008 SHALL have port out_valid, output, 1, product valid.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts product.
REQ-010 SHALL have port q, output, 4, product a*b, normal basis.
REQ-011 SHALL have port ops_done, output, CNT_W, count of delivered products.

Function
REQ-012 SHALL instantiate exactly one gf_muls_2 and time-multiplex it for all three GF(2^2) sub-products.
REQ-013 SHALL compute the shared factors feeding gf_muls_2 locally: ab = X[1]^X[0], cd = Y[1]^Y[0] for the current operands X, Y.
REQ-014 SHALL define M(x,y) as the gf_muls_2 result: M1 = x1y1 ^ (x1^x0)(y1^y0); M0 = x0y0 ^ (x1^x0)(y1^y0).
REQ-015 SHALL define scl(z) = {z[0], z[1]^z[0]} (scale by N), implemented as fixed XOR logic outside gf_muls_2.
REQ-016 SHALL produce q = {ph^e, pl^e}, where ph = M(ah,bh), pl = M(al,bl), and e = scl(M(ah^al, bh^bl)).
REQ-017 SHALL implement FSM states IDLE, S_HI, S_LO, S_MID, DONE.
REQ-018 IDLE: in_ready=1; on in_valid=1, SHALL capture a and b into operand registers and go to S_HI; otherwise stay.
REQ-019 S_HI: multiplier fed (ah,bh); SHALL register ph; go to S_LO.
REQ-020 S_LO: multiplier fed (al,bl); SHALL register pl; go to S_MID.
REQ-021 S_MID: multiplier fed (ah^al, bh^bl); SHALL register q per REQ-016; go to DONE.
REQ-022 DONE: out_valid=1; q stable; on out_ready=1, SHALL go to IDLE and increment ops_done; otherwise hold.
REQ-023 in_ready SHALL be 1 only in IDLE and out_valid SHALL be 1 only in DONE; both are decoded from registered state.
REQ-024 Latency SHALL be 3 cycles from the accept edge: out_valid asserts after the third subsequent rising edge.
REQ-025 Minimum issue interval SHALL be 5 cycles; no overlap and no bypass of DONE to S_HI.
REQ-026 Inputs a and b SHALL be ignored outside IDLE; changes to them during an operation SHALL NOT affect q.
REQ-027 ops_done SHALL wrap modulo 2^CNT_W without saturating.
REQ-028 The multiplier operand mux SHALL drive zeros in IDLE and DONE.

Reset
REQ-029 While rst=1 at a clock edge, the block SHALL enter IDLE and clear q, the operand registers, ph, pl, and ops_done to 0; out_valid=0 and in_ready=1 after that edge.
REQ-030 rst SHALL take priority over all handshakes; a reset in S_HI, S_LO, S_MID or DONE SHALL discard the operation without incrementing ops_done.
REQ-031 in_valid SHALL NOT be accepted on an edge where rst=1.

Verification
REQ-032 Identity: a=4'h6, b=4'hF, out_ready=1 -> q=4'h6 three cycles after accept; ops_done 0->1.
REQ-033 Square: a=4'h6, b=4'h6 -> q=4'h3; inverse pair a=4'h5, b=4'hA -> q=4'hF; zero: a=4'h9, b=4'h0 -> q=4'h0.
REQ-034 Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid stays 1, q is stable, in_ready=0, and ops_done increments only on the release cycle.
REQ-035 Input churn: randomize a and b every cycle after accept -> q equals the product of the captured operands.
REQ-036 Reset mid-op: assert rst in S_LO -> next cycle IDLE, out_valid=0, q=0, ops_done unchanged at 0; the following operation is correct.
REQ-037 Exhaustive: all 256 (a,b) pairs streamed back-to-back -> q matches the REQ-016 model, commutativity holds, throughput is 1 per 5 cycles, and ops_done=0 (CNT_W=8 wrap).

Source files
------------

// File: rtl/gf_muls_4_seq.sv
// Sequential GF(2^4) multiplier (normal basis) that reuses one GF(2^2) multiplier
// over three cycles for the high, low and cross sub-products.

module gf_muls_2 (
  input  logic [1:0] x,
  input  logic [1:0] y,
  input  logic       ab,
  input  logic       cd,
  output logic [1:0] m
);

  logic t;

  assign t = ab & cd;
  assign m = {(x[1] & y[1]) ^ t, (x[0] & y[0]) ^ t};

endmodule

module gf_muls_4_seq #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       q,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S_HI  = 3'd1,
    S_LO  = 3'd2,
    S_MID = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] a_reg;
  logic [3:0] b_reg;
  logic [1:0] ph;
  logic [1:0] pl;
  logic [1:0] mx;
  logic [1:0] my;
  logic       ab;
  logic       cd;
  logic [1:0] m;
  logic [1:0] e;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Operand mux for the shared multiplier; idle states feed zeros.
  always_comb begin
    mx = '0;
    my = '0;
    case (state)
      S_HI: begin
        mx = a_reg[3:2];
        my = b_reg[3:2];
      end
      S_LO: begin
        mx = a_reg[1:0];
        my = b_reg[1:0];
      end
      S_MID: begin
        mx = a_reg[3:2] ^ a_reg[1:0];
        my = b_reg[3:2] ^ b_reg[1:0];
      end
      default: begin
        mx = '0;
        my = '0;
      end
    endcase
  end

  assign ab = mx[1] ^ mx[0];
  assign cd = my[1] ^ my[0];

  gf_muls_2 u_mul (
    .x  (mx),
    .y  (my),
    .ab (ab),
    .cd (cd),
    .m  (m)
  );

  // Scale the cross product by N.
  assign e = {m[0], m[1] ^ m[0]};

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = S_HI;
      S_HI:    state_next = S_LO;
      S_LO:    state_next = S_MID;
      S_MID:   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      ph       <= '0;
      pl       <= '0;
      q        <= '0;
      ops_done <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
          end
        end
        S_HI:  ph <= m;
        S_LO:  pl <= m;
        S_MID: q  <= {ph ^ e, pl ^ e};
        DONE: begin
          if (out_ready) ops_done <= ops_done + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gf_muls_4_seq.sv
// Scoreboard bench for gf_muls_4_seq: expected products are queued at accept
// and compared when the product handshake completes.

module tb_gf_muls_4_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] q;
  logic [7:0] ops_done;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [7:0]  exp_ops = '0;
  logic [3:0]  res[256];
  int unsigned cyc = 0;

  gf_muls_4_seq #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .ops_done  (ops_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] mul2(input logic [1:0] x, input logic [1:0] y);
    logic s;
    s = (x[1] ^ x[0]) & (y[1] ^ y[0]);
    return {(x[1] & y[1]) ^ s, (x[0] & y[0]) ^ s};
  endfunction

  function automatic logic [3:0] gf4(input logic [3:0] x, input logic [3:0] y);
    logic [1:0] hi, lo, mid, sc;
    hi  = mul2(x[3:2], y[3:2]);
    lo  = mul2(x[1:0], y[1:0]);
    mid = mul2(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]);
    sc  = {mid[0], mid[1] ^ mid[0]};
    return {hi ^ sc, lo ^ sc};
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("q", {28'd0, q}, {28'd0, e.q});
        res[{e.a, e.b}] = q;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb, input logic [3:0] req,
                        input int unsigned stall, input bit churn);
    int unsigned lat;
    logic [3:0]  q_hold;
    logic [7:0]  ops_hold;
    lat = 0;
    while (!in_ready && lat < 20) begin
      step();
      lat++;
    end
    check("ready_wait", {31'd0, in_ready}, 32'd1);
    a = ta;
    b = tb;
    in_valid = 1'b1;
    out_ready = (stall == 0);
    sb.push_back('{a: ta, b: tb, q: req});
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      if (churn) begin
        a = 4'($urandom);
        b = 4'($urandom);
      end
      step();
      lat++;
    end
    check("latency", lat, 32'd3);
    if (stall > 0) begin
      q_hold = q;
      ops_hold = ops_done;
      for (int unsigned i = 0; i < stall; i++) begin
        if (churn) begin
          a = 4'($urandom);
          b = 4'($urandom);
        end
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        check("bp_q", {28'd0, q}, {28'd0, q_hold});
        check("bp_ready", {31'd0, in_ready}, 32'd0);
        check("bp_ops", {24'd0, ops_done}, {24'd0, ops_hold});
        step();
      end
      out_ready = 1'b1;
    end
    step();
    exp_ops = exp_ops + 8'd1;
    check("ops_done", {24'd0, ops_done}, {24'd0, exp_ops});
    check("back_idle", {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    int unsigned last_acc;
    int unsigned bad_iv;
    int unsigned bad_comm;
    int unsigned guard;
    logic [3:0] ra, rb;

    rst = 1'b1;
    in_valid = 1'b1;
    a = 4'h3;
    b = 4'h3;
    out_ready = 1'b1;
    repeat (3) step();
    in_valid = 1'b0;
    rst = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_q", {28'd0, q}, 32'd0);
    check("rst_ops", {24'd0, ops_done}, 32'd0);
    step();
    check("idle_after_rst", {31'd0, in_ready}, 32'd1);

    run_op(4'h6, 4'hF, 4'h6, 0, 1'b0);
    run_op(4'h6, 4'h6, 4'h3, 0, 1'b0);
    run_op(4'h5, 4'hA, 4'hF, 0, 1'b0);
    run_op(4'h9, 4'h0, 4'h0, 0, 1'b0);
    run_op(4'hB, 4'h7, gf4(4'hB, 4'h7), 10, 1'b0);
    run_op(4'hD, 4'h3, gf4(4'hD, 4'h3), 0, 1'b1);
    run_op(4'h7, 4'hE, gf4(4'h7, 4'hE), 4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      run_op(ra, rb, gf4(ra, rb), $urandom_range(0, 3), 1'b1);
    end

    // Reset landing in S_LO abandons the operation.
    a = 4'hC;
    b = 4'h5;
    in_valid = 1'b1;
    out_ready = 1'b1;
    sb.push_back('{a: 4'hC, b: 4'h5, q: gf4(4'hC, 4'h5)});
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    void'(sb.pop_back());
    exp_ops = '0;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_q", {28'd0, q}, 32'd0);
    check("mid_rst_ops", {24'd0, ops_done}, 32'd0);
    run_op(4'hC, 4'h5, gf4(4'hC, 4'h5), 0, 1'b0);

    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_ops = '0;

    // Stream every operand pair with in_valid and out_ready held high.
    bad_iv = 0;
    last_acc = 0;
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 256; i++) begin
      a = 4'(i >> 4);
      b = 4'(i);
      in_valid = 1'b1;
      guard = 0;
      while (!in_ready && guard < 20) begin
        step();
        guard++;
      end
      if (!in_ready) check("stream_ready", 32'd0, 32'd1);
      sb.push_back('{a: a, b: b, q: gf4(a, b)});
      if (i > 0 && (cyc - last_acc) != 5) bad_iv++;
      last_acc = cyc;
      step();
    end
    in_valid = 1'b0;
    guard = 0;
    while ((sb.size() != 0 || !in_ready) && guard < 40) begin
      step();
      guard++;
    end
    check("stream_drain", sb.size(), 32'd0);
    check("interval", bad_iv, 32'd0);
    check("wrap_ops", {24'd0, ops_done}, 32'd0);
    bad_comm = 0;
    for (int unsigned i = 0; i < 256; i++) begin
      if (res[i] !== res[{i[3:0], i[7:4]}]) bad_comm++;
    end
    check("commutative", bad_comm, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
